// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with valid/ready flow control.
//
// Carries the EX results (ALU result, store data, PC+4, write-back select,
// destination register, store / register-write flags) into MEM.
// SKID=1 adds a second (skid) entry so that ex_ready comes straight from
// state flops. SKID=0 keeps one entry and a combinational ex_ready.
// flush drops every held beat and any beat accepted in the same cycle.
// A saturating counter records cycles where MEM stalls a valid beat.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop held and incoming beats this cycle
//   ex_valid / ex_ready  EX-side handshake
//   ex_*                 EX payload
//   mem_valid/mem_ready  MEM-side handshake (main entry)
//   mem_*                main-entry payload; memwr/regwr gated by mem_valid
//   mem_stall_cnt        saturating count of mem_valid & !mem_ready cycles
module ex_mem_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned WBSEL_W = 2,
    parameter int unsigned SKID    = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [XLEN-1:0]    ex_alu_res,
    input  logic [XLEN-1:0]    ex_rs2o,
    input  logic [XLEN-1:0]    ex_pcp4,
    input  logic               ex_memwr,
    input  logic               ex_regwr,
    input  logic [WBSEL_W-1:0] ex_wbsel,
    input  logic [RADDR_W-1:0] ex_rdaddr,
    output logic               mem_valid,
    input  logic               mem_ready,
    output logic [XLEN-1:0]    mem_alu_res,
    output logic [XLEN-1:0]    mem_rs2o,
    output logic [XLEN-1:0]    mem_pcp4,
    output logic [WBSEL_W-1:0] mem_wbsel,
    output logic [RADDR_W-1:0] mem_rdaddr,
    output logic               mem_memwr,
    output logic               mem_regwr,
    output logic [CNT_W-1:0]   mem_stall_cnt
);

    localparam int unsigned PW = 3 * XLEN + WBSEL_W + RADDR_W + 2;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

    occ_e            state_q, state_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   ex_beat;
    logic            accept, transfer;
    logic            main_memwr, main_regwr;
    logic [CNT_W-1:0] cnt_q;

    assign ex_beat = {ex_alu_res, ex_rs2o, ex_pcp4, ex_wbsel, ex_rdaddr, ex_memwr, ex_regwr};

    assign mem_valid = (state_q != StEmpty);

    // With a skid entry, ready depends only on occupancy flops.
    always_comb begin
        ex_ready = 1'b0;
        if (SKID != 0) begin
            ex_ready = (state_q != StTwo);
        end else begin
            ex_ready = (state_q == StEmpty) | mem_ready;
        end
    end

    assign accept   = ex_valid & ex_ready;
    assign transfer = mem_valid & mem_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = ex_beat;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && transfer) begin
                    main_d = ex_beat;
                end else if (accept) begin
                    // Only reachable with SKID=1: younger beat parks in skid.
                    skid_d  = ex_beat;
                    state_d = StTwo;
                end else if (transfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (transfer) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins: empty the stage, leave payload untouched.
        if (flush) begin
            state_d = StEmpty;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (mem_valid && !mem_ready && !(&cnt_q)) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign {mem_alu_res, mem_rs2o, mem_pcp4, mem_wbsel, mem_rdaddr, main_memwr, main_regwr} = main_q;

    assign mem_memwr     = main_memwr & mem_valid;
    assign mem_regwr     = main_regwr & mem_valid;
    assign mem_stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed bench for ex_mem_pipe.
// dut1 is the skid variant with a 4-bit stall counter; dut0 is the
// single-entry variant, exercised with random handshakes against a model.
module tb_ex_mem_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // dut1 (SKID=1, CNT_W=4)
    logic        f1 = 1'b0, v1 = 1'b0, r1, mr1 = 1'b0;
    logic [31:0] a1 = '0, s1 = '0, p1 = '0;
    logic        mw1 = 1'b0, rw1 = 1'b0;
    logic [1:0]  wb1 = '0;
    logic [4:0]  rd1 = '0;
    logic        mv1, mmw1, mrw1;
    logic [31:0] ma1, ms1, mp1;
    logic [1:0]  mwb1;
    logic [4:0]  mrd1;
    logic [3:0]  cnt1;

    // dut0 (SKID=0, CNT_W=16)
    logic        v0 = 1'b0, r0, mr0 = 1'b0;
    logic [31:0] a0 = '0;
    logic        mv0, mmw0, mrw0;
    logic [31:0] ma0, ms0, mp0;
    logic [1:0]  mwb0;
    logic [4:0]  mrd0;
    logic [15:0] cnt0;

    ex_mem_pipe #(.XLEN(32), .RADDR_W(5), .WBSEL_W(2), .SKID(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(f1), .ex_valid(v1), .ex_ready(r1),
        .ex_alu_res(a1), .ex_rs2o(s1), .ex_pcp4(p1), .ex_memwr(mw1), .ex_regwr(rw1),
        .ex_wbsel(wb1), .ex_rdaddr(rd1), .mem_valid(mv1), .mem_ready(mr1),
        .mem_alu_res(ma1), .mem_rs2o(ms1), .mem_pcp4(mp1), .mem_wbsel(mwb1),
        .mem_rdaddr(mrd1), .mem_memwr(mmw1), .mem_regwr(mrw1), .mem_stall_cnt(cnt1)
    );

    ex_mem_pipe #(.XLEN(32), .RADDR_W(5), .WBSEL_W(2), .SKID(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .ex_valid(v0), .ex_ready(r0),
        .ex_alu_res(a0), .ex_rs2o(32'h0), .ex_pcp4(32'h0), .ex_memwr(1'b1), .ex_regwr(1'b1),
        .ex_wbsel(2'b01), .ex_rdaddr(5'd7), .mem_valid(mv0), .mem_ready(mr0),
        .mem_alu_res(ma0), .mem_rs2o(ms0), .mem_pcp4(mp0), .mem_wbsel(mwb0),
        .mem_rdaddr(mrd0), .mem_memwr(mmw0), .mem_regwr(mrw0), .mem_stall_cnt(cnt0)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] val, input logic [4:0] rd, input logic mw,
                         input logic rw);
        v1  = 1'b1;
        a1  = val;
        s1  = val ^ 32'h5A5A_5A5A;
        p1  = val + 32'd4;
        wb1 = val[1:0];
        rd1 = rd;
        mw1 = mw;
        rw1 = rw;
    endtask

    logic        m_valid;
    logic [31:0] m_data;
    int          acc_n, del_n;
    logic        exp_rdy;

    initial begin
        // Reset
        step();
        step();
        check_eq("rst_valid", mv1, 1'b0);
        check_eq("rst_alu", ma1, 32'h0);
        check_eq("rst_rs2o", ms1, 32'h0);
        check_eq("rst_pcp4", mp1, 32'h0);
        check_eq("rst_rd", mrd1, 5'd0);
        check_eq("rst_memwr", mmw1, 1'b0);
        check_eq("rst_regwr", mrw1, 1'b0);
        check_eq("rst_cnt", cnt1, 4'd0);
        check_eq("rst_valid0", mv0, 1'b0);
        rst_n = 1'b1;
        check_eq("rst_ready", r1, 1'b1);

        // 8 back-to-back beats, mem_ready high
        mr1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i, i[4:0], 1'b0, 1'b1);
            #1;
            check_eq("b2b_ready", r1, 1'b1);
            step();
            check_eq("b2b_valid", mv1, 1'b1);
            check_eq("b2b_alu", ma1, i);
            check_eq("b2b_rd", mrd1, i);
            if (i == 5) begin
                check_eq("b2b_rs2o", ms1, 32'h5A5A_5A5F);
                check_eq("b2b_pcp4", mp1, 32'd9);
                check_eq("b2b_regwr", mrw1, 1'b1);
            end
        end
        v1 = 1'b0;
        step();
        check_eq("b2b_drain", mv1, 1'b0);
        check_eq("b2b_cnt", cnt1, 4'd0);

        // Back-pressure: A, B taken, C held off
        mr1 = 1'b0;
        offer(32'hA, 5'd10, 1'b0, 1'b1);
        step();
        offer(32'hB, 5'd11, 1'b0, 1'b1);
        check_eq("bp_ready_one", r1, 1'b1);
        step();
        check_eq("bp_ready_two", r1, 1'b0);
        offer(32'hC, 5'd12, 1'b0, 1'b1);
        step();
        check_eq("bp_hold_alu", ma1, 32'hA);
        check_eq("bp_ready_hold", r1, 1'b0);
        mr1 = 1'b1;
        step();
        check_eq("bp_b_alu", ma1, 32'hB);
        check_eq("bp_ready_back", r1, 1'b1);
        step();
        check_eq("bp_c_alu", ma1, 32'hC);
        offer(32'hD, 5'd13, 1'b0, 1'b1);
        step();
        check_eq("bp_d_alu", ma1, 32'hD);
        check_eq("bp_d_rd", mrd1, 5'd13);
        v1 = 1'b0;
        step();
        check_eq("bp_drain", mv1, 1'b0);
        check_eq("bp_cnt", cnt1, 4'd2);

        // Flush while TWO, store in skid, incoming beat offered
        mr1 = 1'b0;
        offer(32'hE, 5'd14, 1'b0, 1'b1);
        step();
        offer(32'hF, 5'd15, 1'b1, 1'b0);
        step();
        check_eq("fl_two_ready", r1, 1'b0);
        check_eq("fl_main_memwr", mmw1, 1'b0);
        offer(32'h10, 5'd16, 1'b1, 1'b1);
        f1  = 1'b1;
        mr1 = 1'b1;
        #1;
        check_eq("fl_same_cycle_valid", mv1, 1'b1);
        check_eq("fl_same_cycle_alu", ma1, 32'hE);
        step();
        f1 = 1'b0;
        v1 = 1'b0;
        check_eq("fl_valid", mv1, 1'b0);
        check_eq("fl_memwr", mmw1, 1'b0);
        check_eq("fl_regwr", mrw1, 1'b0);
        check_eq("fl_payload_held", ma1, 32'hE);
        check_eq("fl_ready", r1, 1'b1);
        // Flush in ONE with a store accepted the same cycle
        mr1 = 1'b0;
        offer(32'h11, 5'd17, 1'b0, 1'b1);
        step();
        offer(32'h12, 5'd18, 1'b1, 1'b1);
        f1 = 1'b1;
        check_eq("fl1_accept_ready", r1, 1'b1);
        step();
        f1 = 1'b0;
        v1 = 1'b0;
        check_eq("fl1_valid", mv1, 1'b0);
        check_eq("fl1_memwr", mmw1, 1'b0);
        mr1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fl_no_ghost", mv1, 1'b0);
        end
        offer(32'h13, 5'd19, 1'b0, 1'b1);
        step();
        v1 = 1'b0;
        check_eq("fl_recover_valid", mv1, 1'b1);
        check_eq("fl_recover_alu", ma1, 32'h13);
        step();

        // Reset while TWO
        mr1 = 1'b0;
        offer(32'h21, 5'd3, 1'b1, 1'b1);
        step();
        offer(32'h22, 5'd4, 1'b1, 1'b1);
        step();
        v1 = 1'b0;
        step();
        check_eq("mr_two_ready", r1, 1'b0);
        check_eq("mr_pre_memwr", mmw1, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("mr_valid", mv1, 1'b0);
        check_eq("mr_alu", ma1, 32'h0);
        check_eq("mr_rd", mrd1, 5'd0);
        check_eq("mr_memwr", mmw1, 1'b0);
        check_eq("mr_regwr", mrw1, 1'b0);
        check_eq("mr_cnt", cnt1, 4'd0);
        check_eq("mr_ready", r1, 1'b1);
        step();
        check_eq("mr_no_skid_leak", mv1, 1'b0);

        // Counter saturation
        offer(32'h31, 5'd5, 1'b0, 1'b1);
        step();
        v1 = 1'b0;
        check_eq("sat_start", cnt1, 4'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            check_eq("sat_cnt", cnt1, (i > 15) ? 15 : i);
        end
        mr1 = 1'b1;
        step();
        check_eq("sat_drain", mv1, 1'b0);
        step();
        check_eq("sat_hold", cnt1, 4'd15);

        // SKID=0 random handshakes against a single-entry model
        m_valid = 1'b0;
        m_data  = '0;
        acc_n   = 0;
        del_n   = 0;
        for (int c = 0; c < 1000; c++) begin
            v0  = 1'($urandom_range(0, 1));
            mr0 = 1'($urandom_range(0, 1));
            a0  = acc_n;
            @(negedge clk);
            exp_rdy = !m_valid | mr0;
            check_eq("s0_ready", r0, exp_rdy);
            check_eq("s0_valid", mv0, m_valid);
            if (m_valid) begin
                check_eq("s0_data", ma0, m_data);
                if (mr0) del_n++;
            end
            if (v0 && exp_rdy) begin
                m_valid = 1'b1;
                m_data  = acc_n;
                acc_n++;
            end else if (m_valid && mr0) begin
                m_valid = 1'b0;
            end
            step();
        end
        v0 = 1'b0;
        check_eq("s0_count", del_n, acc_n - (m_valid ? 1 : 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
